// File: rtl/button_press_conditioner.sv
// Synchronises and debounces the nine active-low cell keys and turns a
// debounced press into a single held selection with a valid/ack handshake.
module button_press_conditioner #(
  parameter int N_BUTTONS       = 9,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int IDX_W           = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] buttons_n,
  input  logic                 enable,
  input  logic                 ack,
  output logic                 press_valid,
  output logic [IDX_W-1:0]     press_index,
  output logic [N_BUTTONS-1:0] press_onehot,
  output logic [N_BUTTONS-1:0] stable_pressed,
  output logic                 multi_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_RELEASE,
    IDLE,
    HOLD
  } state_t;

  state_t state, state_d;

  logic [N_BUTTONS-1:0] meta_n;
  logic [N_BUTTONS-1:0] sync_n;
  logic [N_BUTTONS-1:0] diff;
  logic [CNT_W-1:0]     cnt [N_BUTTONS];

  logic                 valid_d;
  logic [IDX_W-1:0]     index_d;
  logic [N_BUTTONS-1:0] onehot_d;
  logic                 multi_d;
  logic [IDX_W-1:0]     low_idx;
  logic [N_BUTTONS-1:0] low_oh;
  logic                 many;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_n <= '1;
      sync_n <= '1;
    end else begin
      meta_n <= buttons_n;
      sync_n <= meta_n;
    end
  end

  // a bit disagrees when its synchronised pressed level differs from the debounced one
  assign diff = ~sync_n ^ stable_pressed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable_pressed <= '0;
      for (int i = 0; i < N_BUTTONS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_BUTTONS; i++) begin
        if (!diff[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          stable_pressed[i] <= ~stable_pressed[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // lowest held key wins; low_oh isolates the lowest set bit
  assign low_oh = stable_pressed & ~(stable_pressed - N_BUTTONS'(1));
  assign many   = |(stable_pressed & (stable_pressed - N_BUTTONS'(1)));

  always_comb begin
    low_idx = '0;
    for (int i = N_BUTTONS - 1; i >= 0; i--) begin
      if (stable_pressed[i]) low_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_d  = state;
    valid_d  = press_valid;
    index_d  = press_index;
    onehot_d = press_onehot;
    multi_d  = 1'b0;
    unique case (state)
      WAIT_RELEASE: begin
        if (stable_pressed == '0) state_d = IDLE;
      end
      IDLE: begin
        if (enable && |stable_pressed) begin
          state_d  = HOLD;
          valid_d  = 1'b1;
          index_d  = low_idx;
          onehot_d = low_oh;
          multi_d  = many;
        end
      end
      HOLD: begin
        if (ack) begin
          state_d  = WAIT_RELEASE;
          valid_d  = 1'b0;
          onehot_d = '0;
        end
      end
      default: state_d = WAIT_RELEASE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= WAIT_RELEASE;
      press_valid  <= 1'b0;
      press_index  <= '0;
      press_onehot <= '0;
      multi_press  <= 1'b0;
    end else begin
      state        <= state_d;
      press_valid  <= valid_d;
      press_index  <= index_d;
      press_onehot <= onehot_d;
      multi_press  <= multi_d;
    end
  end

endmodule

// File: tb/tb_button_press_conditioner.sv
// Bench for button_press_conditioner: directed scenarios then random key
// activity, checked against a sample-window reference model and scoreboard.
module tb_button_press_conditioner;

  localparam int N  = 9;
  localparam int D  = 4;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  buttons_n = '1;
  logic          enable = 1'b0;
  logic          ack = 1'b0;
  logic          press_valid;
  logic [IW-1:0] press_index;
  logic [N-1:0]  press_onehot;
  logic [N-1:0]  stable_pressed;
  logic          multi_press;

  button_press_conditioner #(
    .N_BUTTONS(N),
    .DEBOUNCE_CYCLES(D),
    .IDX_W(IW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .buttons_n(buttons_n),
    .enable(enable),
    .ack(ack),
    .press_valid(press_valid),
    .press_index(press_index),
    .press_onehot(press_onehot),
    .stable_pressed(stable_pressed),
    .multi_press(multi_press)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [IW-1:0] idx;
    logic [N-1:0]  oh;
    logic          multi;
  } sel_t;

  int vectors = 0;
  int miscompares = 0;

  logic [N-1:0]  m_stable;
  logic [N-1:0]  m_oh;
  logic [IW-1:0] m_idx;
  bit            m_pending;
  bit            m_armed;
  logic [N-1:0]  hist [$];
  sel_t          exp_q [$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_stable  = '0;
    m_oh      = '0;
    m_idx     = '0;
    m_pending = 1'b0;
    m_armed   = 1'b0;
    hist.delete();
    repeat (2 + D) hist.push_back('0);
  endtask

  // Debounced level follows the raw level seen two edges earlier once
  // that level has been seen on D consecutive edges.
  task automatic model_step();
    logic [N-1:0] s;
    sel_t e;
    int cnt;
    bit all;
    s = m_stable;
    if (m_pending) begin
      if (ack) begin
        m_pending = 1'b0;
        m_armed   = 1'b0;
        m_oh      = '0;
      end
    end else if (!m_armed) begin
      if (s == '0) m_armed = 1'b1;
    end else if (enable && s != '0) begin
      cnt = 0;
      e.idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
        if (s[i]) begin
          e.idx = IW'(i);
          cnt++;
        end
      end
      e.oh = '0;
      e.oh[e.idx] = 1'b1;
      e.multi = (cnt > 1);
      exp_q.push_back(e);
      m_pending = 1'b1;
      m_idx = e.idx;
      m_oh = e.oh;
    end
    hist.push_back(~buttons_n);
    void'(hist.pop_front());
    for (int i = 0; i < N; i++) begin
      all = 1'b1;
      for (int k = 0; k < D; k++) begin
        if (hist[hist.size() - 3 - k][i] == s[i]) all = 1'b0;
      end
      if (all) m_stable[i] = ~s[i];
    end
  endtask

  task automatic model_loop();
    forever begin
      @(posedge clk);
      if (reset) model_reset();
      else model_step();
    end
  endtask

  task automatic monitor_loop();
    logic prev = 1'b0;
    sel_t e;
    forever begin
      @(negedge clk);
      chk("stable_pressed", 32'(stable_pressed), 32'(m_stable));
      chk("press_valid", 32'(press_valid), 32'(m_pending));
      chk("press_onehot", 32'(press_onehot), 32'(m_oh));
      chk("press_index", 32'(press_index), 32'(m_idx));
      if (press_valid && !prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_select", 32'(1), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("sel_index", 32'(press_index), 32'(e.idx));
          chk("sel_onehot", 32'(press_onehot), 32'(e.oh));
          chk("sel_multi", 32'(multi_press), 32'(e.multi));
        end
      end else begin
        chk("multi_quiet", 32'(multi_press), 32'(0));
      end
      prev = press_valid;
    end
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_valid(int max);
    bit seen = 1'b0;
    for (int c = 0; c < max && !seen; c++) begin
      @(negedge clk);
      if (press_valid) seen = 1'b1;
    end
    chk("valid_timeout", 32'(seen), 32'(1));
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    cyc(1);
    ack = 1'b0;
  endtask

  initial begin
    model_reset();
    fork
      model_loop();
      monitor_loop();
    join_none

    cyc(2);
    reset = 1'b0;
    cyc(6);

    enable = 1'b1;
    buttons_n[4] = 1'b0;
    wait_valid(20);
    cyc(3);
    ack_pulse();
    buttons_n = '1;
    cyc(10);

    buttons_n[2] = 1'b0;
    cyc(3);
    buttons_n[2] = 1'b1;
    cyc(10);

    buttons_n[7] = 1'b0;
    buttons_n[3] = 1'b0;
    wait_valid(20);
    cyc(2);
    ack_pulse();
    cyc(12);
    buttons_n = '1;
    cyc(10);
    buttons_n[7] = 1'b0;
    wait_valid(20);
    ack_pulse();
    buttons_n = '1;
    cyc(10);

    enable = 1'b0;
    buttons_n[0] = 1'b0;
    cyc(10);
    enable = 1'b1;
    wait_valid(5);
    ack_pulse();
    buttons_n = '1;
    cyc(10);

    buttons_n[5] = 1'b0;
    wait_valid(20);
    cyc(2);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_valid", 32'(press_valid), 32'(0));
    chk("async_onehot", 32'(press_onehot), 32'(0));
    chk("async_index", 32'(press_index), 32'(0));
    chk("async_stable", 32'(stable_pressed), 32'(0));
    chk("async_multi", 32'(multi_press), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    buttons_n = '1;
    cyc(12);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0)
        buttons_n = buttons_n ^ (N'(1) << $urandom_range(0, N - 1));
      if ($urandom_range(0, 24) == 0) buttons_n = '1;
      if ($urandom_range(0, 29) == 0) enable = ~enable;
      ack = ($urandom_range(0, 3) == 0);
    end
    ack = 1'b0;
    buttons_n = '1;
    cyc(20);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/button_press_conditioner.md
Name: button_press_conditioner

Overview:
- Upstream stage feeding the game FSM's `buttons` input.
- Takes the 9 raw active-low board keys and synchronises and debounces each one.
- Turns a debounced press into one accepted cell selection, held with a valid/ack handshake until the user-move logic consumes it.
- Accepts only while `enable` is high (game in user-playing state) and requires a full release before the next selection.

Parameters:
- N_BUTTONS, 9, number of cell keys (board cells 0..8).
- DEBOUNCE_CYCLES, 8, consecutive stable synchronised cycles required to change a debounced level (min 2).
- IDX_W, 4, width of press_index.

Ports:
- clk  in  1  system clock (divided game clock).
- reset  in  1  asynchronous, active-high reset.
- buttons_n  in  N_BUTTONS  raw keys, active-low, asynchronous to clk.
- enable  in  1  high while the FSM accepts a user move.
- ack  in  1  consumer has taken the current selection.
- press_valid  out  1  a selection is pending.
- press_index  out  IDX_W  binary cell index of the pending selection.
- press_onehot  out  N_BUTTONS  one-hot of the pending selection, 0 when not valid.
- stable_pressed  out  N_BUTTONS  debounced levels, active-high (1 = held).
- multi_press  out  1  one-cycle pulse when a capture sees more than one debounced key held.

Behaviour:
- Reset (async, active-high) values:
  - sync flops = all ones (released).
  - stable_pressed = 0; all debounce counters = 0.
  - state = WAIT_RELEASE.
  - press_valid = 0, press_index = 0, press_onehot = 0, multi_press = 0.
- Reset asserted mid-operation drops any pending selection immediately.
- Synchroniser: 2-flop per bit. sync_n is buttons_n delayed 2 clk edges.
- Debounce, per bit i:
  - Counter increments each cycle that ~sync_n[i] != stable_pressed[i].
  - Any cycle where they are equal clears the counter.
  - When the counter = DEBOUNCE_CYCLES-1 and the bit still differs, stable_pressed[i] toggles and the counter clears.
  - A clean edge on buttons_n reaches stable_pressed after exactly 2+DEBOUNCE_CYCLES edges.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never changes stable_pressed.
- FSM states:
  - WAIT_RELEASE: go to IDLE when stable_pressed == 0.
  - IDLE: when enable=1 and stable_pressed != 0:
    - capture the lowest-index held key into press_index and press_onehot.
    - press_valid <= 1 on the same edge.
    - multi_press pulses if more than one bit is set.
    - go to HOLD.
    - If enable=0, presses are ignored; the FSM stays in IDLE while keys are held.
  - HOLD: press_valid, press_index and press_onehot stay constant regardless of key activity or enable.
    - On an edge with ack=1: press_valid <= 0, press_onehot <= 0, go to WAIT_RELEASE.
    - press_index retains its last value.
- Latency: stable_pressed rising edge to press_valid high is 1 clk, when in IDLE with enable=1.
- A key already held when enable rises is captured 1 clk after enable is sampled high.
- ack while press_valid=0 is ignored.
- ack on the same edge press_valid rises is not honoured; it must be sampled while press_valid=1.
- Keys held through ack produce no second selection until all keys are released and debounced.
- Same-edge tie: if several bits rise in stable_pressed on the same edge, the lowest index wins and multi_press pulses.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset, then all keys released for 6 cycles -> state IDLE; press_valid=0; stable_pressed=0.
- enable=1, buttons_n[4] driven low and held -> stable_pressed[4]=1 at edge 6 after the drive; press_valid=1, press_index=4, press_onehot=9'b000010000 at edge 7; values held until ack. With ack pulsed, press_valid=0 on the next edge.
- buttons_n[2] low for 3 cycles then high, enable=1 -> stable_pressed stays 0; press_valid never asserts.
- buttons_n[7] and [3] low on the same cycle, enable=1 -> press_index=3; multi_press pulses once. After ack with keys still held, no new press_valid; after release plus a press on [7], press_index=7.
- enable=0 while buttons_n[0] held, then enable=1 after 10 cycles -> press_valid rises 1 clk after enable is sampled high, press_index=0.
- In HOLD with press_index=5, assert reset for 1 cycle -> all outputs 0 asynchronously. After reset falls with keys released, IDLE is reached and no stale selection reappears.
